// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS datapath: controller states, mux selects,
// funct codes and the internal ALU operation.
package mc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    // Unknown funct codes fall back to add.
    function automatic alu_op_e alu_decode(logic [1:0] aluop, logic [5:0] funct);
        alu_op_e res;
        res = AluAdd;
        case (aluop)
            ALUOP_SUB: res = AluSub;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: res = AluSub;
                    FUNCT_AND: res = AluAnd;
                    FUNCT_OR:  res = AluOr;
                    FUNCT_SLT: res = AluSlt;
                    default:   res = AluAdd;
                endcase
            end
            default: res = AluAdd;
        endcase
        return res;
    endfunction

    function automatic logic [XLEN-1:0] sext16(logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// r0 is never written and always reads zero.
module mc_regfile
    import mc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    input  logic [4:0]      waddr,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, controller state register,
// ALU and register file, steered by strobes from the combinational controller.
module multicycle_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [3:0]  RESET_STATE = 4'd0,
    parameter logic [3:0]  MAX_STATE   = 4'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ns,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        MemtoReg,
    input  logic [1:0]  PCSource,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  ALUSrcB,
    input  logic        ALUSrcA,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  cs,
    output logic [5:0]  op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] pc,
    output logic        zero
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [3:0]  cs_q, cs_d;
    logic        pc_en;

    logic [31:0] src_a, src_b, imm_ext, alu_result, jump_target;
    logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic [4:0]  rf_waddr;
    alu_op_e     alu_op;

    assign imm_ext     = sext16(ir_q[15:0]);
    assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        src_a = ALUSrcA ? a_q : pc_q;
        src_b = b_q;
        case (ALUSrcB)
            SRCB_B:      src_b = b_q;
            SRCB_FOUR:   src_b = 32'd4;
            SRCB_IMM:    src_b = imm_ext;
            SRCB_IMM_SH: src_b = {imm_ext[29:0], 2'b00};
            default:     src_b = b_q;
        endcase
    end

    always_comb begin
        alu_op     = alu_decode(ALUOp, ir_q[5:0]);
        alu_result = src_a + src_b;
        case (alu_op)
            AluAdd:  alu_result = src_a + src_b;
            AluSub:  alu_result = src_a - src_b;
            AluAnd:  alu_result = src_a & src_b;
            AluOr:   alu_result = src_a | src_b;
            AluSlt:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = src_a + src_b;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    always_comb begin
        pc_en = PCWrite | (PCWriteCond & zero);
        pc_d  = pc_q;
        case (PCSource)
            PCSRC_ALU:    pc_d = alu_result;
            PCSRC_ALUOUT: pc_d = aluout_q;
            PCSRC_JUMP:   pc_d = jump_target;
            PCSRC_HOLD:   pc_d = pc_q;
            default:      pc_d = pc_q;
        endcase
    end

    // Out-of-range next states fall back to fetch so a glitching controller recovers.
    assign cs_d = (ns > MAX_STATE) ? RESET_STATE : ns;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            cs_q     <= RESET_STATE;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            cs_q     <= cs_d;
            mdr_q    <= mem_rdata;
            a_q      <= rf_rdata1;
            b_q      <= rf_rdata2;
            aluout_q <= alu_result;
            if (pc_en) begin
                pc_q <= pc_d;
            end
            if (IRWrite) begin
                ir_q <= mem_rdata;
            end
        end
    end

    assign rf_waddr = RegDst ? ir_q[15:11] : ir_q[20:16];
    assign rf_wdata = MemtoReg ? mdr_q : aluout_q;

    mc_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (ir_q[25:21]),
        .raddr2 (ir_q[20:16]),
        .waddr  (rf_waddr),
        .we     (RegWrite),
        .wdata  (rf_wdata),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    assign cs        = cs_q;
    assign op        = ir_q[31:26];
    assign mem_addr  = IorD ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed instruction walk-throughs followed by randomized
// control strobes, all compared against an architectural-level reference model.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  ns;
    logic        PCWrite, PCWriteCond, IorD, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [31:0] mem_rdata;
    logic [3:0]  cs;
    logic [5:0]  op;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic        zero;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural state of the reference model
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_rf [32];
    logic [3:0]  m_cs;

    multicycle_datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ns          (ns),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .mem_rdata   (mem_rdata),
        .cs          (cs),
        .op          (op),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .pc          (pc),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] model_alu();
        logic [31:0] x, y, imm;
        imm = {{16{m_ir[15]}}, m_ir[15:0]};
        x   = ALUSrcA ? m_a : m_pc;
        case (ALUSrcB)
            2'd0:    y = m_b;
            2'd1:    y = 32'd4;
            2'd2:    y = imm;
            default: y = imm * 4;
        endcase
        if (ALUOp == 2'b01) return x - y;
        if (ALUOp == 2'b10) begin
            case (m_ir[5:0])
                6'd34:   return x - y;
                6'd36:   return x & y;
                6'd37:   return x | y;
                6'd42:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                default: return x + y;
            endcase
        end
        return x + y;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0; m_cs = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
    endtask

    task automatic model_edge();
        logic [31:0] res, na, nb, wdata;
        logic [4:0]  dst;
        res   = model_alu();
        na    = m_rf[m_ir[25:21]];
        nb    = m_rf[m_ir[20:16]];
        dst   = RegDst ? m_ir[15:11] : m_ir[20:16];
        wdata = MemtoReg ? m_mdr : m_aluout;
        if (PCWrite || (PCWriteCond && res == 0)) begin
            case (PCSource)
                2'd0:    m_pc = res;
                2'd1:    m_pc = m_aluout;
                2'd2:    m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
                default: m_pc = m_pc;
            endcase
        end
        if (IRWrite) m_ir = mem_rdata;
        m_mdr    = mem_rdata;
        m_a      = na;
        m_b      = nb;
        m_aluout = res;
        if (RegWrite && dst != 0) m_rf[dst] = wdata;
        m_cs = (ns > 4'd9) ? 4'd0 : ns;
    endtask

    task automatic clear_ctl();
        ns = 0; PCWrite = 0; PCWriteCond = 0; IorD = 0; IRWrite = 0; MemtoReg = 0;
        PCSource = 0; ALUOp = 0; ALUSrcB = 0; ALUSrcA = 0; RegWrite = 0; RegDst = 0;
        mem_rdata = 0;
    endtask

    // One clock: check combinational outputs, take the edge, check registered outputs.
    task automatic cycle();
        #1;
        check_eq("zero", {31'd0, zero}, {31'd0, model_alu() == 0});
        check_eq("mem_addr", mem_addr, IorD ? m_aluout : m_pc);
        @(posedge clk);
        model_edge();
        #1;
        check_eq("cs", {28'd0, cs}, {28'd0, m_cs});
        check_eq("op", {26'd0, op}, {26'd0, m_ir[31:26]});
        check_eq("pc", pc, m_pc);
        check_eq("mem_wdata", mem_wdata, m_b);
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_cs", {28'd0, cs}, 32'h0);
        check_eq("rst_op", {26'd0, op}, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] functs [5];
        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b101010;
        clear_ctl();
        #2;
        do_reset();

        // Fetch of lw $2,4($1)
        clear_ctl(); ns = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; mem_rdata = 32'h8C220004;
        cycle();
        check_eq("fetch_pc", pc, 32'd4);
        check_eq("fetch_op", {26'd0, op}, {26'd0, 6'b100011});
        check_eq("fetch_cs", {28'd0, cs}, 32'd1);
        clear_ctl(); ns = 2; ALUSrcB = 2'b11;
        cycle();
        clear_ctl(); ns = 3; ALUSrcA = 1; ALUSrcB = 2'b10;
        cycle();
        clear_ctl(); ns = 4; IorD = 1; mem_rdata = 32'hDEADBEEF;
        #1 check_eq("lw_addr", mem_addr, 32'd4);
        cycle();
        clear_ctl(); ns = 0; MemtoReg = 1; RegWrite = 1;
        cycle();
        clear_ctl();
        cycle();
        check_eq("lw_r2", mem_wdata, 32'hDEADBEEF);

        // beq $0,$0 taken
        clear_ctl(); ns = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; mem_rdata = 32'h10000003;
        cycle();
        clear_ctl(); ns = 8; ALUSrcB = 2'b11;
        cycle();
        clear_ctl(); ALUSrcA = 1; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01;
        #1 check_eq("beq_zero1", {31'd0, zero}, 32'd1);
        cycle();
        check_eq("beq_taken_pc", pc, 32'd20);

        // beq $2,$0 not taken
        clear_ctl(); ns = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; mem_rdata = 32'h10400003;
        cycle();
        clear_ctl(); ns = 8; ALUSrcB = 2'b11;
        cycle();
        clear_ctl(); ALUSrcA = 1; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01;
        #1 check_eq("beq_zero0", {31'd0, zero}, 32'd0);
        cycle();
        check_eq("beq_nt_pc", pc, 32'd24);

        // Build r3 = 0x1000_0000, steer PC to 0x1000_0004, then jump
        clear_ctl(); IRWrite = 1; mem_rdata = 32'h00630000;
        cycle();
        clear_ctl(); mem_rdata = 32'h10000000;
        cycle();
        clear_ctl(); MemtoReg = 1; RegWrite = 1;
        cycle();
        clear_ctl();
        cycle();
        clear_ctl(); ALUSrcA = 1; ALUSrcB = 2'b01; PCWrite = 1;
        cycle();
        check_eq("pre_j_pc", pc, 32'h1000_0004);
        clear_ctl(); IRWrite = 1; mem_rdata = 32'h08000010;
        cycle();
        clear_ctl(); ns = 9; PCWrite = 1; PCSource = 2'b10;
        cycle();
        check_eq("j_pc", pc, 32'h1000_0040);

        // Write to r0 via rd=0 is dropped
        clear_ctl(); RegWrite = 1; RegDst = 1;
        cycle();
        clear_ctl();
        cycle();
        check_eq("r0_zero", mem_wdata, 32'd0);

        // State register bounds
        clear_ctl(); ns = 9;
        cycle();
        check_eq("cs_max", {28'd0, cs}, 32'd9);
        clear_ctl(); ns = 10;
        cycle();
        check_eq("cs_10", {28'd0, cs}, 32'd0);
        clear_ctl(); ns = 5;
        cycle();
        clear_ctl(); ns = 12;
        cycle();
        check_eq("cs_12", {28'd0, cs}, 32'd0);

        // slt: r4 = -1, r5 = 1
        clear_ctl(); IRWrite = 1; mem_rdata = 32'h0085202A;
        cycle();
        clear_ctl(); mem_rdata = 32'hFFFFFFFF;
        cycle();
        clear_ctl(); MemtoReg = 1; RegWrite = 1; RegDst = 1; mem_rdata = 32'd1;
        cycle();
        clear_ctl(); MemtoReg = 1; RegWrite = 1;
        cycle();
        clear_ctl();
        cycle();
        clear_ctl(); ns = 6; ALUSrcA = 1; ALUOp = 2'b10;
        cycle();
        clear_ctl(); IorD = 1;
        #1 check_eq("slt", mem_addr, 32'd1);
        cycle();

        // Reset in the middle of a memory-read state
        clear_ctl(); ns = 3; ALUSrcB = 2'b01; PCWrite = 1;
        cycle();
        check_eq("cs_memrd", {28'd0, cs}, 32'd3);
        clear_ctl(); ns = 4;
        do_reset();
        clear_ctl(); ns = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; mem_rdata = 32'h8C220004;
        cycle();
        check_eq("refetch_pc", pc, 32'd4);

        // Randomized strobes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                clear_ctl();
                do_reset();
            end
            ns          = 4'($urandom_range(0, 15));
            PCWrite     = ($urandom_range(0, 3) == 0);
            PCWriteCond = ($urandom_range(0, 3) == 0);
            IorD        = 1'($urandom);
            IRWrite     = ($urandom_range(0, 2) == 0);
            MemtoReg    = 1'($urandom);
            PCSource    = 2'($urandom);
            ALUOp       = 2'($urandom);
            ALUSrcB     = 2'($urandom);
            ALUSrcA     = 1'($urandom);
            RegWrite    = 1'($urandom);
            RegDst      = 1'($urandom);
            mem_rdata   = $urandom;
            if ($urandom_range(0, 1) == 0) mem_rdata[5:0] = functs[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) mem_rdata[25:16] = 10'($urandom_range(0, 7) * 33);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
